// File: rtl/dqs_burst_gen.sv
// DQS burst sequencer: registered preamble/toggle/postamble words and per-lane tristates for the DQS OSERDES.
// Optional macro DQS_BURST_CHAIN_EN accepts a back-to-back burst in the final cycle of the current one.
module dqs_burst_gen #(
    parameter int NUM_LANES   = 2,
    parameter int SER_WIDTH   = 4,
    parameter int LEN_W       = 8,
    parameter int PRE_CYCLES  = 1,
    parameter int POST_CYCLES = 1,
    parameter int FIRST_BIT   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [LEN_W-1:0]               len,
    input  logic [NUM_LANES-1:0]           lane_en,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_LANES*SER_WIDTH-1:0] ser_data,
    output logic [NUM_LANES-1:0]           ser_tri,
    output logic [1:0]                     dbg_state
);

    localparam int CNT_W = (LEN_W < 4) ? 4 : LEN_W;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_TOGGLE, S_POST} state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [LEN_W-1:0]                 len_q, len_d;
    logic [NUM_LANES-1:0]             mask_q, mask_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic [NUM_LANES*SER_WIDTH-1:0]   ser_data_q, ser_data_d;
    logic [NUM_LANES-1:0]             ser_tri_q, ser_tri_d;
    logic                             last_cycle;
    logic [SER_WIDTH-1:0]             toggle_word;

    always_comb begin
        toggle_word = '0;
        for (int k = 0; k < SER_WIDTH; k++) begin
            toggle_word[k] = FIRST_BIT[0] ^ k[0];
        end
    end

    // cnt_q holds the cycles left in the current phase, including this one.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        mask_d     = mask_q;
        done_d     = 1'b0;
        last_cycle = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        len_d  = len;
                        mask_d = lane_en;
                        if (PRE_CYCLES > 0) begin
                            state_d = S_PRE;
                            cnt_d   = CNT_W'(PRE_CYCLES);
                        end else begin
                            state_d = S_TOGGLE;
                            cnt_d   = CNT_W'(len);
                        end
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_PRE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_TOGGLE;
                    cnt_d   = CNT_W'(len_q);
                end
            end
            S_TOGGLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (POST_CYCLES > 0) begin
                        state_d = S_POST;
                        cnt_d   = CNT_W'(POST_CYCLES);
                    end else begin
                        last_cycle = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    last_cycle = 1'b1;
                end
            end
        endcase

        if (last_cycle) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
`ifdef DQS_BURST_CHAIN_EN
            // Chained burst skips the preamble: the strobe is already running.
            if (start && (len != '0)) begin
                state_d = S_TOGGLE;
                cnt_d   = CNT_W'(len);
                len_d   = len;
                mask_d  = lane_en;
            end
`endif
        end

        busy_d     = (state_d != S_IDLE);
        ser_tri_d  = busy_d ? ~mask_d : '1;
        ser_data_d = '0;
        if (state_d == S_TOGGLE) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (mask_d[i]) begin
                    ser_data_d[i*SER_WIDTH +: SER_WIDTH] = toggle_word;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            mask_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ser_data_q <= '0;
            ser_tri_q  <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            mask_q     <= mask_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ser_data_q <= ser_data_d;
            ser_tri_q  <= ser_tri_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ser_data  = ser_data_q;
    assign ser_tri   = ser_tri_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dqs_burst_gen.sv
// Directed bench for dqs_burst_gen: instance a (FIRST_BIT=1, PRE=1, POST=1) and
// instance b (FIRST_BIT=0, PRE=0, POST=0) share the same stimulus.
module tb_dqs_burst_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic [1:0] lane_en;

    logic       busy_a, done_a, busy_b, done_b;
    logic [7:0] data_a, data_b;
    logic [1:0] tri_a, tri_b, st_a, st_b;

    int errors = 0;
    int checks = 0;

    dqs_burst_gen #(
        .NUM_LANES(2), .SER_WIDTH(4), .LEN_W(8),
        .PRE_CYCLES(1), .POST_CYCLES(1), .FIRST_BIT(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .len(len), .lane_en(lane_en),
        .busy(busy_a), .done(done_a), .ser_data(data_a), .ser_tri(tri_a),
        .dbg_state(st_a)
    );

    dqs_burst_gen #(
        .NUM_LANES(2), .SER_WIDTH(4), .LEN_W(8),
        .PRE_CYCLES(0), .POST_CYCLES(0), .FIRST_BIT(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .len(len), .lane_en(lane_en),
        .busy(busy_b), .done(done_b), .ser_data(data_b), .ser_tri(tri_b),
        .dbg_state(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic b, input logic d,
                           input logic [7:0] data, input logic [1:0] tr);
        chk({tag, ".a.busy"}, 32'(busy_a), 32'(b));
        chk({tag, ".a.done"}, 32'(done_a), 32'(d));
        chk({tag, ".a.data"}, 32'(data_a), 32'(data));
        chk({tag, ".a.tri"},  32'(tri_a),  32'(tr));
    endtask

    task automatic check_b(input string tag, input logic b, input logic d,
                           input logic [7:0] data, input logic [1:0] tr);
        chk({tag, ".b.busy"}, 32'(busy_b), 32'(b));
        chk({tag, ".b.done"}, 32'(done_b), 32'(d));
        chk({tag, ".b.data"}, 32'(data_b), 32'(data));
        chk({tag, ".b.tri"},  32'(tri_b),  32'(tr));
    endtask

    task automatic req(input logic [7:0] l, input logic [1:0] m);
        start   = 1'b1;
        len     = l;
        lane_en = m;
    endtask

    task automatic idle_inputs();
        start   = 1'b0;
        len     = 8'd0;
        lane_en = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        check_a("reset", 1'b0, 1'b0, 8'h00, 2'b11);
        check_b("reset", 1'b0, 1'b0, 8'h00, 2'b11);
        chk("reset.a.state", 32'(st_a), 32'd0);
        chk("reset.b.state", 32'(st_b), 32'd0);
        rst = 1'b0;
        tick();

        // len=3, both lanes
        req(8'd3, 2'b11);
        tick();
        idle_inputs();
        check_a("b1.t1", 1'b1, 1'b0, 8'h00, 2'b00);
        check_b("b1.t1", 1'b1, 1'b0, 8'hAA, 2'b00);
        tick();
        check_a("b1.t2", 1'b1, 1'b0, 8'h55, 2'b00);
        check_b("b1.t2", 1'b1, 1'b0, 8'hAA, 2'b00);
        tick();
        check_a("b1.t3", 1'b1, 1'b0, 8'h55, 2'b00);
        check_b("b1.t3", 1'b1, 1'b0, 8'hAA, 2'b00);
        tick();
        check_a("b1.t4", 1'b1, 1'b0, 8'h55, 2'b00);
        check_b("b1.t4", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();
        check_a("b1.t5", 1'b1, 1'b0, 8'h00, 2'b00);
        check_b("b1.t5", 1'b0, 1'b0, 8'h00, 2'b11);
        tick();
        check_a("b1.t6", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();
        check_a("b1.t7", 1'b0, 1'b0, 8'h00, 2'b11);

        // len=2, lane 1 only
        req(8'd2, 2'b10);
        tick();
        idle_inputs();
        check_a("b2.t1", 1'b1, 1'b0, 8'h00, 2'b01);
        check_b("b2.t1", 1'b1, 1'b0, 8'hA0, 2'b01);
        tick();
        check_a("b2.t2", 1'b1, 1'b0, 8'h50, 2'b01);
        check_b("b2.t2", 1'b1, 1'b0, 8'hA0, 2'b01);
        tick();
        check_a("b2.t3", 1'b1, 1'b0, 8'h50, 2'b01);
        check_b("b2.t3", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();
        check_a("b2.t4", 1'b1, 1'b0, 8'h00, 2'b01);
        tick();
        check_a("b2.t5", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();

        // len=0: immediate done, no drive
        req(8'd0, 2'b11);
        tick();
        idle_inputs();
        check_a("len0.t1", 1'b0, 1'b1, 8'h00, 2'b11);
        check_b("len0.t1", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();
        check_a("len0.t2", 1'b0, 1'b0, 8'h00, 2'b11);
        check_b("len0.t2", 1'b0, 1'b0, 8'h00, 2'b11);

        // all-zero mask keeps normal timing
        req(8'd1, 2'b00);
        tick();
        idle_inputs();
        check_a("mask0.t1", 1'b1, 1'b0, 8'h00, 2'b11);
        check_b("mask0.t1", 1'b1, 1'b0, 8'h00, 2'b11);
        tick();
        check_a("mask0.t2", 1'b1, 1'b0, 8'h00, 2'b11);
        check_b("mask0.t2", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();
        check_a("mask0.t3", 1'b1, 1'b0, 8'h00, 2'b11);
        tick();
        check_a("mask0.t4", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();

        // len=5, start while busy at T+3, reset at T+4
        req(8'd5, 2'b11);
        tick();
        idle_inputs();
        tick();
        tick();
        req(8'd2, 2'b01);
        check_a("rst.t3", 1'b1, 1'b0, 8'h55, 2'b00);
        check_b("rst.t3", 1'b1, 1'b0, 8'hAA, 2'b00);
        tick();
        idle_inputs();
        check_a("rst.t4", 1'b1, 1'b0, 8'h55, 2'b00);
        check_b("rst.t4", 1'b1, 1'b0, 8'hAA, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_a("rst.t5", 1'b0, 1'b0, 8'h00, 2'b11);
        check_b("rst.t5", 1'b0, 1'b0, 8'h00, 2'b11);
        tick();
        check_a("rst.t6", 1'b0, 1'b0, 8'h00, 2'b11);
        req(8'd1, 2'b11);
        tick();
        idle_inputs();
        check_a("post_rst.t1", 1'b1, 1'b0, 8'h00, 2'b00);
        check_b("post_rst.t1", 1'b1, 1'b0, 8'hAA, 2'b00);
        tick();
        check_a("post_rst.t2", 1'b1, 1'b0, 8'h55, 2'b00);
        check_b("post_rst.t2", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();
        check_a("post_rst.t3", 1'b1, 1'b0, 8'h00, 2'b00);
        tick();
        check_a("post_rst.t4", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();

        // start in a's last POST cycle (lane 0, then both lanes)
        req(8'd1, 2'b01);
        tick();
        idle_inputs();
        tick();
        tick();
        check_a("ch.t3", 1'b1, 1'b0, 8'h00, 2'b10);
        check_b("ch.t3", 1'b0, 1'b0, 8'h00, 2'b11);
        req(8'd2, 2'b11);
        tick();
        idle_inputs();
        check_b("ch.t4", 1'b1, 1'b0, 8'hAA, 2'b00);
`ifdef DQS_BURST_CHAIN_EN
        check_a("ch.t4", 1'b1, 1'b1, 8'h55, 2'b00);
        tick();
        check_a("ch.t5", 1'b1, 1'b0, 8'h55, 2'b00);
        check_b("ch.t5", 1'b1, 1'b0, 8'hAA, 2'b00);
        tick();
        check_a("ch.t6", 1'b1, 1'b0, 8'h00, 2'b00);
        check_b("ch.t6", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();
        check_a("ch.t7", 1'b0, 1'b1, 8'h00, 2'b11);
`else
        check_a("ch.t4", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();
        check_a("ch.t5", 1'b0, 1'b0, 8'h00, 2'b11);
        check_b("ch.t5", 1'b1, 1'b0, 8'hAA, 2'b00);
        tick();
        check_b("ch.t6", 1'b0, 1'b1, 8'h00, 2'b11);
`endif
        tick();
        tick();

        // start in b's final TOGGLE cycle (POST=0); a is in PRE and ignores it
        req(8'd1, 2'b11);
        tick();
        req(8'd1, 2'b10);
        check_b("chb.t1", 1'b1, 1'b0, 8'hAA, 2'b00);
        tick();
        idle_inputs();
        check_a("chb.t2", 1'b1, 1'b0, 8'h55, 2'b00);
`ifdef DQS_BURST_CHAIN_EN
        check_b("chb.t2", 1'b1, 1'b1, 8'hA0, 2'b01);
        tick();
        check_b("chb.t3", 1'b0, 1'b1, 8'h00, 2'b11);
`else
        check_b("chb.t2", 1'b0, 1'b1, 8'h00, 2'b11);
        tick();
        check_b("chb.t3", 1'b0, 1'b0, 8'h00, 2'b11);
`endif
        check_a("chb.t3", 1'b1, 1'b0, 8'h00, 2'b00);
        tick();
        check_a("chb.t4", 1'b0, 1'b1, 8'h00, 2'b11);
        check_b("chb.t4", 1'b0, 1'b0, 8'h00, 2'b11);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
